id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage MIPS core; sits directly downstream of the ID-stage control unit and register file.
- Captures the control buses (execute_bus, memory_bus, writeBack_bus) plus operands and register addresses, and presents them to the EX stage.
- Contains the load-use hazard detector. It drives the stall to PC/IF-ID and inserts a bubble. It also handles branch/jump flush and the debug-unit step enable.

---
 rtl/id_ex_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection, flush and debug step hold.
// Latency: ID inputs appear on ex_* one clk after the capturing edge; stall is combinational in the same cycle.
// Backpressure: a load-use hazard raises stall for one cycle and turns the EX slot into a bubble; enable=0 freezes everything.
//
// Ports:
//   clk, reset (async, active-low), enable (debug step), flush (branch/jump taken)
//   id_*  : control buses, PC+4, operands, immediate and register fields from the ID stage
//   ex_*  : registered copies presented to the EX stage
//   stall : load-use stall to PC and IF/ID
//   bubble_count : saturating count of load-use bubbles inserted
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [8:0]        id_execute_bus,
  input  logic [2:0]        id_memory_bus,
  input  logic [1:0]        id_writeBack_bus,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [REG_W-1:0]  id_shamt,
  output logic [8:0]        ex_execute_bus,
  output logic [2:0]        ex_memory_bus,
  output logic [1:0]        ex_writeBack_bus,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [REG_W-1:0]  ex_shamt,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_count
);

  logic ex_is_load;
  logic rt_match;
  logic squash;

  // MemRead is bit 1 of {Branch, MemRead, MemWrite}.
  assign ex_is_load = ex_memory_bus[1];

  // Conservative: compares against id_rt even when the ID instruction does not read rt.
  // r0 is never a real dependence.
  assign rt_match = (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Gated by enable so stall never asserts while frozen, and by flush so a
  // squashed instruction cannot also stall or be counted.
  assign stall = enable & ~flush & ex_is_load & rt_match;

  // Either condition empties the control buses of the EX slot.
  assign squash = flush | stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_execute_bus   <= '0;
      ex_memory_bus    <= '0;
      ex_writeBack_bus <= '0;
      ex_pc            <= '0;
      ex_rs_data       <= '0;
      ex_rt_data       <= '0;
      ex_imm           <= '0;
      ex_rs            <= '0;
      ex_rt            <= '0;
      ex_rd            <= '0;
      ex_shamt         <= '0;
      bubble_count     <= '0;
    end else if (enable) begin
      // Data and address fields always follow ID; only control is zeroed.
      ex_pc      <= id_pc;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_shamt   <= id_shamt;
      if (squash) begin
        ex_execute_bus   <= '0;
        ex_memory_bus    <= '0;
        ex_writeBack_bus <= '0;
      end else begin
        ex_execute_bus   <= id_execute_bus;
        ex_memory_bus    <= id_memory_bus;
        ex_writeBack_bus <= id_writeBack_bus;
      end
      if (stall && (bubble_count != {CNT_W{1'b1}})) begin
        bubble_count <= bubble_count + 1'b1;
      end
    end
  end

endmodule
